sd_spi_master: RTL

Parametrised SPI master for SD-card access in SPI mode. It sits between the CPU-side I/O port logic and the card pins. It generalises the single-byte SD SPI engine with:
- programmable slow/fast clock dividers and a configurable init-clock count;
- multi-byte burst transfers with a byte-level handshake;
- a hardware "wait for response token" poll with timeout;
- asynchronous active-low reset.

---
 rtl/sd_spi_master_if.sv | 31 +++
 rtl/sd_spi_master.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_master_if.sv
// sd_spi_master_if: command/data handshake between the CPU-side port logic
// and the SD-card SPI engine.
//   cmd_valid/cmd/cmd_len/tx_data : command strobe, ID, burst length-1, byte/argument
//   tx_ready                      : pulse, tx_data was latched, present the next byte
//   rx_data/rx_valid              : received byte and its update strobe
//   busy/timeout/fast             : engine status
// The "master" modport is the command issuer, "slave" is the SPI engine.
interface sd_spi_master_if #(
    parameter int LEN_W = 10
);
    logic             cmd_valid;
    logic [2:0]       cmd;
    logic [LEN_W-1:0] cmd_len;
    logic [7:0]       tx_data;
    logic             tx_ready;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             busy;
    logic             timeout;
    logic             fast;

    modport master (
        output cmd_valid, cmd, cmd_len, tx_data,
        input  tx_ready, rx_data, rx_valid, busy, timeout, fast
    );

    modport slave (
        input  cmd_valid, cmd, cmd_len, tx_data,
        output tx_ready, rx_data, rx_valid, busy, timeout, fast
    );
endinterface

// File: rtl/sd_spi_master.sv
// sd_spi_master: SPI-mode (mode 0) master for SD-card access.
//   clock, reset_n  : system clock, asynchronous active-low reset
//   SPI_CS/SCLK/MOSI: card pins driven by the master (CS active low, SCLK idles low)
//   SPI_MISO        : card data out
//   bus (slave)     : command handshake, see sd_spi_master_if
// Commands: 0 INIT clocks, 1 burst XFER, 2 CS low, 3 CS high,
//           4 WAIT for non-FF token with timeout, 5 SPEED select, 6/7 ignored.
module sd_spi_master #(
    parameter int SLOW_DIV    = 125,
    parameter int FAST_DIV    = 1,
    parameter int INIT_CLOCKS = 80,
    parameter int TIMEOUT_CNT = 2500000,
    parameter int LEN_W       = 10
) (
    input  logic clock,
    input  logic reset_n,
    output logic SPI_CS,
    output logic SPI_SCLK,
    input  logic SPI_MISO,
    output logic SPI_MOSI,
    sd_spi_master_if.slave bus
);
    localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int DIV_W   = $clog2(MAX_DIV + 1);
    localparam int INIT_W  = $clog2(INIT_CLOCKS + 1);
    localparam int TO_W0   = $clog2(TIMEOUT_CNT + 1);
    localparam int TO_W    = (TO_W0 < 22) ? 22 : TO_W0;

    localparam logic [DIV_W-1:0]  SLOW_LIM  = DIV_W'(SLOW_DIV - 1);
    localparam logic [DIV_W-1:0]  FAST_LIM  = DIV_W'(FAST_DIV - 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CLOCKS - 1);
    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT_CNT);

    typedef enum logic [2:0] {IDLE, INIT, XFER, WAIT, CS} state_t;

    state_t            state_reg,    state_next;
    logic [2:0]        cmd_reg,      cmd_next;
    logic              arg_reg,      arg_next;
    logic [LEN_W-1:0]  len_reg,      len_next;
    logic [DIV_W-1:0]  div_reg,      div_next;
    logic [DIV_W-1:0]  lim_reg,      lim_next;
    logic [2:0]        bit_reg,      bit_next;
    logic [INIT_W-1:0] init_reg,     init_next;
    logic [TO_W-1:0]   to_reg,       to_next;
    logic [7:0]        shift_reg,    shift_next;
    logic              sclk_reg,     sclk_next;
    logic              mosi_reg,     mosi_next;
    logic              cs_reg,       cs_next;
    logic [7:0]        rx_data_reg,  rx_data_next;
    logic              rx_valid_reg, rx_valid_next;
    logic              tx_ready_reg, tx_ready_next;
    logic              timeout_reg,  timeout_next;
    logic              fast_reg,     fast_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            cmd_reg      <= '0;
            arg_reg      <= 1'b0;
            len_reg      <= '0;
            div_reg      <= '0;
            lim_reg      <= '0;
            bit_reg      <= '0;
            init_reg     <= '0;
            to_reg       <= '0;
            shift_reg    <= '0;
            sclk_reg     <= 1'b0;
            mosi_reg     <= 1'b1;
            cs_reg       <= 1'b1;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            tx_ready_reg <= 1'b0;
            timeout_reg  <= 1'b0;
            fast_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cmd_reg      <= cmd_next;
            arg_reg      <= arg_next;
            len_reg      <= len_next;
            div_reg      <= div_next;
            lim_reg      <= lim_next;
            bit_reg      <= bit_next;
            init_reg     <= init_next;
            to_reg       <= to_next;
            shift_reg    <= shift_next;
            sclk_reg     <= sclk_next;
            mosi_reg     <= mosi_next;
            cs_reg       <= cs_next;
            rx_data_reg  <= rx_data_next;
            rx_valid_reg <= rx_valid_next;
            tx_ready_reg <= tx_ready_next;
            timeout_reg  <= timeout_next;
            fast_reg     <= fast_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cmd_next      = cmd_reg;
        arg_next      = arg_reg;
        len_next      = len_reg;
        div_next      = div_reg;
        lim_next      = lim_reg;
        bit_next      = bit_reg;
        init_next     = init_reg;
        to_next       = to_reg;
        shift_next    = shift_reg;
        sclk_next     = sclk_reg;
        mosi_next     = mosi_reg;
        cs_next       = cs_reg;
        rx_data_next  = rx_data_reg;
        rx_valid_next = 1'b0;
        tx_ready_next = 1'b0;
        timeout_next  = timeout_reg;
        fast_next     = fast_reg;

        case (state_reg)
            IDLE: begin
                // IDs 6 and 7 are not commands: nothing is captured, busy stays low.
                if (bus.cmd_valid && (bus.cmd <= 3'd5)) begin
                    cmd_next     = bus.cmd;
                    arg_next     = bus.tx_data[0];
                    len_next     = bus.cmd_len;
                    timeout_next = 1'b0;
                    to_next      = '0;
                    div_next     = '0;
                    bit_next     = '0;
                    init_next    = '0;
                    sclk_next    = 1'b0;
                    lim_next     = fast_reg ? FAST_LIM : SLOW_LIM;
                    case (bus.cmd)
                        3'd0: begin
                            state_next = INIT;
                            cs_next    = 1'b1;
                            mosi_next  = 1'b1;
                            lim_next   = SLOW_LIM;
                        end
                        3'd1: begin
                            state_next    = XFER;
                            shift_next    = bus.tx_data;
                            mosi_next     = bus.tx_data[7];
                            tx_ready_next = 1'b1;
                        end
                        3'd4: begin
                            state_next = WAIT;
                            shift_next = 8'hFF;
                            mosi_next  = 1'b1;
                        end
                        default: state_next = CS;
                    endcase
                end
            end
            CS: begin
                case (cmd_reg)
                    3'd2:    cs_next   = 1'b0;
                    3'd3:    cs_next   = 1'b1;
                    default: fast_next = arg_reg;
                endcase
                state_next = IDLE;
            end
            default: begin
                // INIT, XFER and WAIT share the SCLK divider.
                if ((state_reg == WAIT) && (to_reg != TO_MAX))
                    to_next = to_reg + 1'b1;
                if (div_reg != lim_reg) begin
                    div_next = div_reg + 1'b1;
                end else begin
                    div_next  = '0;
                    sclk_next = ~sclk_reg;
                    if (!sclk_reg) begin
                        // Rising edge: tx bits leave the top while rx bits enter
                        // the bottom, so one register serves both directions.
                        if (state_reg != INIT)
                            shift_next = {shift_reg[6:0], SPI_MISO};
                    end else if (state_reg == INIT) begin
                        if (init_reg == INIT_LAST) begin
                            state_next = IDLE;
                            mosi_next  = 1'b1;
                        end else begin
                            init_next = init_reg + 1'b1;
                        end
                    end else begin
                        bit_next = bit_reg + 1'b1;
                        if (bit_reg != 3'd7) begin
                            mosi_next = shift_reg[7];
                        end else if (state_reg == XFER) begin
                            rx_data_next  = shift_reg;
                            rx_valid_next = 1'b1;
                            if (len_reg == '0) begin
                                state_next = IDLE;
                                mosi_next  = 1'b1;
                            end else begin
                                len_next      = len_reg - 1'b1;
                                shift_next    = bus.tx_data;
                                mosi_next     = bus.tx_data[7];
                                tx_ready_next = 1'b1;
                            end
                        end else begin
                            // WAIT: a token ends the poll; an expired budget ends
                            // it only at a byte boundary, still reporting the byte.
                            if ((shift_reg != 8'hFF) || (to_reg == TO_MAX)) begin
                                rx_data_next  = shift_reg;
                                rx_valid_next = 1'b1;
                                timeout_next  = (shift_reg == 8'hFF);
                                state_next    = IDLE;
                                mosi_next     = 1'b1;
                            end else begin
                                shift_next = 8'hFF;
                            end
                        end
                    end
                end
            end
        endcase
    end

    assign SPI_CS       = cs_reg;
    assign SPI_SCLK     = sclk_reg;
    assign SPI_MOSI     = mosi_reg;
    assign bus.tx_ready = tx_ready_reg;
    assign bus.rx_data  = rx_data_reg;
    assign bus.rx_valid = rx_valid_reg;
    assign bus.busy     = (state_reg != IDLE);
    assign bus.timeout  = timeout_reg;
    assign bus.fast     = fast_reg;
endmodule
